// File: rtl/gpio_pl_driver.sv
// GPIO PL driver: per-pin takeover/drive registers plus a sampled readback.
// A command updates the masked pins, waits cmd_hold+1 edges for the pins to
// settle, then returns a synchronized snapshot and its delta against the
// previous snapshot.

// Per-pin slice: input synchronizer plus takeover and drive bits.
module gpio_pl_pin (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic mask,
   input  logic value,
   input  logic takeover,
   input  logic pin_i,
   output logic t,
   output logic o,
   output logic sync
);

   logic meta;

   // Two-flop synchronizer, free-running so the snapshot is always fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= pin_i;
         sync <= meta;
      end
   end

   // Masked pins take the command's takeover/value on accept; others hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t <= 1'b0;
         o <= 1'b0;
      end else if (load && mask) begin
         t <= takeover;
         o <= value;
      end
   end

endmodule

module gpio_pl_driver #(
   parameter int NUM_PINS = 32,
   parameter int HOLD_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [NUM_PINS-1:0] cmd_mask,
   input  logic [NUM_PINS-1:0] cmd_value,
   input  logic                cmd_takeover,
   input  logic [HOLD_W-1:0]   cmd_hold,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [NUM_PINS-1:0] rsp_data,
   output logic [NUM_PINS-1:0] rsp_changed,
   output logic [NUM_PINS-1:0] gpio_t,
   output logic [NUM_PINS-1:0] pl_gpio_o,
   input  logic [NUM_PINS-1:0] pl_gpio_i,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

   typedef struct packed {
      logic [NUM_PINS-1:0] mask;
      logic [NUM_PINS-1:0] value;
      logic                takeover;
      logic [HOLD_W-1:0]   hold;
   } cmd_t;

   typedef struct packed {
      logic [NUM_PINS-1:0] data;
      logic [NUM_PINS-1:0] changed;
   } rsp_t;

   state_t              state_q, state_d;
   cmd_t                cmd;
   rsp_t                rsp_q;
   logic [HOLD_W-1:0]   cnt_q;
   logic [NUM_PINS-1:0] sync_q;
   logic [NUM_PINS-1:0] last_snap;
   logic                rsp_valid_q;
   logic                accept;
   logic                sample;

   assign cmd = '{mask: cmd_mask, value: cmd_value, takeover: cmd_takeover, hold: cmd_hold};

   assign accept = cmd_valid && (state_q == IDLE);
   assign sample = (state_q == HOLD) && (cnt_q == '0);

   genvar g;
   generate
      for (g = 0; g < NUM_PINS; g++) begin : g_pin
         gpio_pl_pin u_pin (
            .clk      (clk),
            .rst      (rst),
            .load     (accept),
            .mask     (cmd.mask[g]),
            .value    (cmd.value[g]),
            .takeover (cmd.takeover),
            .pin_i    (pl_gpio_i[g]),
            .t        (gpio_t[g]),
            .o        (pl_gpio_o[g]),
            .sync     (sync_q[g])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: accept -> settle -> present response until consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid) state_d = HOLD;
         HOLD:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Settle counter: loaded on accept, counts down to zero in HOLD (no wrap).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      cnt_q <= '0;
      else if (accept)                              cnt_q <= cmd.hold;
      else if ((state_q == HOLD) && (cnt_q != '0))  cnt_q <= cnt_q - 1'b1;
   end

   // Snapshot capture and response handshake; payload frozen while in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q       <= '0;
         last_snap   <= '0;
         rsp_valid_q <= 1'b0;
      end else if (sample) begin
         rsp_q.data    <= sync_q;
         rsp_q.changed <= sync_q ^ last_snap;
         last_snap     <= sync_q;
         rsp_valid_q   <= 1'b1;
      end else if ((state_q == RESP) && rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_q.data;
   assign rsp_changed = rsp_q.changed;
   assign busy        = (state_q != IDLE);
   // Gate with rst so the handshake is closed for the whole reset interval.
   assign cmd_ready   = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_gpio_pl_driver.sv
// Scoreboard bench for gpio_pl_driver: a driver issues commands and pushes the
// expected snapshot; a negedge monitor pops and compares on each handshake.
module tb_gpio_pl_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_mask = '0;
   logic [31:0] cmd_value = '0;
   logic        cmd_takeover = 1'b0;
   logic [15:0] cmd_hold = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [31:0] rsp_changed;
   logic [31:0] gpio_t;
   logic [31:0] pl_gpio_o;
   logic [31:0] pl_gpio_i = '0;
   logic        busy;

   gpio_pl_driver dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_mask     (cmd_mask),
      .cmd_value    (cmd_value),
      .cmd_takeover (cmd_takeover),
      .cmd_hold     (cmd_hold),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_changed  (rsp_changed),
      .gpio_t       (gpio_t),
      .pl_gpio_o    (pl_gpio_o),
      .pl_gpio_i    (pl_gpio_i),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: what the pin router should see, and the last snapshot.
   logic [31:0] m_t, m_o, m_last;
   logic [63:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: payload stability while valid, and compare on each handshake.
   logic        p_valid = 1'b0;
   logic [31:0] p_data, p_chg;
   always @(negedge clk) begin
      if (rst) begin
         p_valid = 1'b0;
      end else begin
         if (rsp_valid && p_valid) begin
            chk("rsp_data_stable", rsp_data, p_data);
            chk("rsp_changed_stable", rsp_changed, p_chg);
         end
         if (rsp_valid && exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
         end else if (rsp_valid && rsp_ready) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e[63:32]);
            chk("rsp_changed", rsp_changed, e[31:0]);
         end
         p_valid = rsp_valid && !rsp_ready;
         p_data  = rsp_data;
         p_chg   = rsp_changed;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      #3;
      chk("rst_gpio_t", gpio_t, 32'h0);
      chk("rst_pl_gpio_o", pl_gpio_o, 32'h0);
      chk("rst_rsp", {rsp_valid, busy, cmd_ready}, 3'b000);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_changed", rsp_changed, 32'h0);
      m_t = '0; m_o = '0; m_last = '0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", {31'b0, cmd_ready}, 32'h1);
   endtask

   // Present the pin value, let it settle through the synchronizer, accept.
   task automatic accept_cmd(input logic [31:0] mask, input logic [31:0] value,
                             input logic tk, input logic [15:0] hold, input logic [31:0] pin);
      pl_gpio_i = pin;
      repeat (2) begin @(posedge clk); #1; end
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'h1);
      cmd_mask = mask; cmd_value = value; cmd_takeover = tk; cmd_hold = hold;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      // Later field changes must be ignored.
      cmd_mask = $urandom; cmd_value = $urandom; cmd_takeover = 1'($urandom); cmd_hold = 16'($urandom);
      for (int i = 0; i < 32; i++) if (mask[i]) begin m_t[i] = tk; m_o[i] = value[i]; end
      chk("gpio_t_accept", gpio_t, m_t);
      chk("pl_gpio_o_accept", pl_gpio_o, m_o);
      exp_q.push_back({pin, pin ^ m_last});
      m_last = pin;
   endtask

   task automatic wait_rsp(input int hold);
      int n = 0;
      bit busy_ok = 1'b1;
      while (1) begin
         @(posedge clk); #1;
         n++;
         if (!busy) busy_ok = 1'b0;
         if (rsp_valid || n > hold + 10) break;
      end
      chk("rsp_latency", 32'(n), 32'(hold + 1));
      chk("busy_in_cmd", {31'b0, busy_ok}, 32'h1);
   endtask

   task automatic finish_rsp(input int d, input bit junk);
      if (junk) begin
         cmd_valid = 1'b1; cmd_mask = '1; cmd_value = $urandom; cmd_takeover = ~m_t[0];
      end
      repeat (d) begin @(posedge clk); #1; end
      chk("cmd_ready_resp", {31'b0, cmd_ready}, 32'h0);
      chk("gpio_t_no_accept", gpio_t, m_t);
      chk("pl_gpio_o_no_accept", pl_gpio_o, m_o);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("idle_after_hs", {30'b0, cmd_ready, rsp_valid}, 32'h2);
   endtask

   task automatic run_cmd(input logic [31:0] mask, input logic [31:0] value, input logic tk,
                          input logic [15:0] hold, input logic [31:0] pin, input int d, input bit junk);
      accept_cmd(mask, value, tk, hold, pin);
      wait_rsp(int'(hold));
      finish_rsp(d, junk);
   endtask

   initial begin
      do_reset();
      // Takeover of the low byte, hold 3.
      run_cmd(32'h0000_00FF, 32'h0000_00A5, 1'b1, 16'd3, $urandom, 0, 1'b0);
      chk("takeover_t", gpio_t, 32'h0000_00FF);
      chk("takeover_o", pl_gpio_o, 32'h0000_00A5);
      // Release the low nibble; drive bits there already match.
      run_cmd(32'h0000_000F, 32'h0000_0005, 1'b0, 16'd1, $urandom, 1, 1'b0);
      chk("release_t", gpio_t, 32'h0000_00F0);
      chk("release_o", pl_gpio_o, 32'h0000_00A5);
      // Snapshot delta: first after reset is the full value, repeat gives 0.
      do_reset();
      run_cmd(32'h0, 32'h0, 1'b0, 16'd0, 32'h1234_5678, 0, 1'b0);
      run_cmd(32'h0, 32'h0, 1'b0, 16'd0, 32'h1234_5678, 0, 1'b0);
      chk("pure_sample_t", gpio_t, 32'h0);
      // Stalled response with a pending command that must not be taken.
      run_cmd(32'hFFFF_0000, 32'hDEAD_BEEF, 1'b1, 16'd2, 32'hCAFE_0001, 10, 1'b1);
      run_cmd(32'h0000_FF00, 32'h0000_1200, 1'b1, 16'd0, 32'h0F0F_0F0F, 0, 1'b0);
      // Reset in HOLD aborts the command and releases every pin at once.
      accept_cmd(32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1, 16'd20, 32'h0000_0001);
      chk("all_taken", gpio_t, 32'hFFFF_FFFF);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_gpio_t", gpio_t, 32'h0);
      chk("abort_pl_gpio_o", pl_gpio_o, 32'h0);
      chk("abort_flags", {29'b0, rsp_valid, busy, cmd_ready}, 32'h0);
      void'(exp_q.pop_back());
      m_t = '0; m_o = '0; m_last = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) begin @(posedge clk); #1; end
      chk("no_rsp_after_abort", {30'b0, rsp_valid, busy}, 32'h0);
      // Randomized traffic.
      for (int k = 0; k < 30; k++) begin
         run_cmd($urandom, $urandom, 1'($urandom), 16'($urandom_range(0, 12)), $urandom,
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
      // Longest settle time: 65536 edges with no counter wrap.
      run_cmd(32'h8000_0001, 32'h8000_0000, 1'b1, 16'hFFFF, 32'h7654_3210, 0, 1'b0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
